z80_in_wait_ctrl: RTL and testbench

Z80 IN-cycle responder for slow I/O read ports, downstream of the video block's LE18 read path. It detects an IN cycle to the configured port and holds the Z80 in wait while the pixel RAM read completes. It latches the byte on the source's ready pulse, then drives it onto the bus read path until the IN cycle ends. An optional watchdog releases the bus with a fixed value if the source never answers.

---
 rtl/z80_in_wait_ctrl.sv | 116 +++++++++++
 tb/tb_z80_in_wait_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_in_wait_ctrl.sv
// Z80 IN-cycle responder: stalls the CPU on reads of SLOW_PORT until the slow source answers.
// Optional watchdog release is built when IN_WAIT_TIMEOUT_EN is defined.
module z80_in_wait_ctrl #(
  parameter logic [7:0] SLOW_PORT    = 8'hEC,
  parameter logic [7:0] TIMEOUT      = 8'd32,
  parameter logic [7:0] TIMEOUT_DATA = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TRS_A,
  input  logic       TRS_IN,
  input  logic [7:0] src_dout,
  input  logic       src_dout_rdy,
  output logic       TRS_WAIT,
  output logic [7:0] TRS_Q,
  output logic       TRS_Q_OE,
  output logic       busy,
  output logic       timeout_flag
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    HOLD     = 2'd2,
    TOUT     = 2'd3
  } state_t;

  state_t     state_q;
  logic       in_d_q;
  logic       hit_d;
  logic       hit_q;
  logic       trs_wait_q;
  logic [7:0] trs_q_q;
  logic       trs_q_oe_q;
`ifdef IN_WAIT_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       tflag_q;
`endif

  // Only a rising edge of TRS_IN on our port starts a transaction; the
  // registered hit gives the two-clock TRS_IN-to-WAIT latency.
  assign hit_d = TRS_IN & ~in_d_q & (TRS_A == SLOW_PORT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      in_d_q     <= 1'b0;
      hit_q      <= 1'b0;
      trs_wait_q <= 1'b0;
      trs_q_q    <= 8'h00;
      trs_q_oe_q <= 1'b0;
`ifdef IN_WAIT_TIMEOUT_EN
      wdog_q     <= 8'd0;
      tflag_q    <= 1'b0;
`endif
    end else begin
      in_d_q <= TRS_IN;
      hit_q  <= hit_d;
      unique case (state_q)
        IDLE: begin
          if (hit_q) begin
            state_q    <= WAIT_RDY;
            trs_wait_q <= 1'b1;
`ifdef IN_WAIT_TIMEOUT_EN
            wdog_q     <= 8'd0;
`endif
          end
        end
        WAIT_RDY: begin
          // Abort outranks a simultaneous ready; the byte is then dropped.
          if (!TRS_IN) begin
            trs_wait_q <= 1'b0;
            state_q    <= IDLE;
          end else if (src_dout_rdy) begin
            trs_q_q    <= src_dout;
            trs_wait_q <= 1'b0;
            trs_q_oe_q <= 1'b1;
            state_q    <= HOLD;
          end
`ifdef IN_WAIT_TIMEOUT_EN
          else if (wdog_q == TIMEOUT - 8'd1) begin
            trs_q_q    <= TIMEOUT_DATA;
            trs_wait_q <= 1'b0;
            trs_q_oe_q <= 1'b1;
            tflag_q    <= 1'b1;
            state_q    <= TOUT;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
`endif
        end
        HOLD, TOUT: begin
          if (!TRS_IN) begin
            trs_q_oe_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TRS_WAIT = trs_wait_q;
  assign TRS_Q    = trs_q_q;
  assign TRS_Q_OE = trs_q_oe_q;
  assign busy     = (state_q != IDLE);

`ifdef IN_WAIT_TIMEOUT_EN
  assign timeout_flag = tflag_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{TIMEOUT, TIMEOUT_DATA};
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_z80_in_wait_ctrl.sv
// Bench for z80_in_wait_ctrl: transaction-level reference model feeding an expected
// queue, with a monitor that checks each end-of-wait event against it.
module tb_z80_in_wait_ctrl;

  localparam logic [7:0] SLOW_PORT    = 8'hEC;
  localparam int         TIMEOUT      = 32;
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
`ifdef IN_WAIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] TRS_A;
  logic       TRS_IN;
  logic [7:0] src_dout;
  logic       src_dout_rdy;
  logic       TRS_WAIT;
  logic [7:0] TRS_Q;
  logic       TRS_Q_OE;
  logic       busy;
  logic       timeout_flag;

  always #5 clk = ~clk;

  z80_in_wait_ctrl #(
    .SLOW_PORT   (SLOW_PORT),
    .TIMEOUT     (8'(TIMEOUT)),
    .TIMEOUT_DATA(TIMEOUT_DATA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .TRS_A       (TRS_A),
    .TRS_IN      (TRS_IN),
    .src_dout    (src_dout),
    .src_dout_rdy(src_dout_rdy),
    .TRS_WAIT    (TRS_WAIT),
    .TRS_Q       (TRS_Q),
    .TRS_Q_OE    (TRS_Q_OE),
    .busy        (busy),
    .timeout_flag(timeout_flag)
  );

  // scoreboard: {presents_data, timeout_flag, wait_cycles[7:0], q[7:0]}
  logic [17:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  model_q;
  bit          model_flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_data, input logic [7:0] q, input int wl);
    exp_q.push_back({is_data, model_flag, wl[7:0], q});
  endtask

  // monitor: every falling edge of TRS_WAIT ends one expected event
  int         wait_cnt  = 0;
  bit         prev_wait = 1'b0;
  bit         prev_oe   = 1'b0;
  logic [7:0] held_q    = 8'h00;

  always @(negedge clk) begin : mon
    logic [17:0] e;
    if (TRS_WAIT === 1'b1) begin
      wait_cnt++;
    end else if (prev_wait) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wait_end: no event queued at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("ev_oe", TRS_Q_OE, e[17]);
        check("ev_tflag", timeout_flag, e[16]);
        check("ev_wait_len", wait_cnt, e[15:8]);
        check("ev_q", TRS_Q, e[7:0]);
      end
      wait_cnt = 0;
    end
    if (TRS_Q_OE === 1'b1 && prev_oe) check("hold_q_stable", TRS_Q, held_q);
    check("oe_wait_exclusive", TRS_Q_OE & TRS_WAIT, 0);
    check("idle_outputs_quiet", (busy === 1'b0) ? {TRS_WAIT, TRS_Q_OE} : 2'b00, 0);
    prev_wait = (TRS_WAIT === 1'b1);
    prev_oe   = (TRS_Q_OE === 1'b1);
    held_q    = TRS_Q;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic end_in();
    TRS_IN = 1'b0;
    @(negedge clk);
    check("oe_before_fall", TRS_Q_OE, 1);
    tick();
    @(negedge clk);
    check("oe_after_fall", TRS_Q_OE, 0);
    check("busy_after_fall", busy, 0);
  endtask

  task automatic apply_reset_checks(input string tag);
    reset  = 1'b1;
    TRS_IN = 1'b0;
    tick();
    reset      = 1'b0;
    model_q    = 8'h00;
    model_flag = 1'b0;
    @(negedge clk);
    check({tag, "_wait"}, TRS_WAIT, 0);
    check({tag, "_oe"}, TRS_Q_OE, 0);
    check({tag, "_q"}, TRS_Q, 8'h00);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tflag"}, timeout_flag, 0);
  endtask

  // Read with src_dout_rdy pulsed d cycles after the TRS_IN rise (d >= 2).
  task automatic do_read(input int d, input logic [7:0] data, input int hold, input bit rst_in_hold);
    if (TO_EN && (d - 2 >= TIMEOUT)) begin
      model_q    = TIMEOUT_DATA;
      model_flag = 1'b1;
      push_ev(1'b1, model_q, TIMEOUT);
    end else begin
      model_q = data;
      push_ev(1'b1, data, d - 1);
    end
    TRS_A  = SLOW_PORT;
    TRS_IN = 1'b1;
    repeat (d) tick();
    src_dout     = data;
    src_dout_rdy = 1'b1;
    tick();
    src_dout_rdy = 1'b0;
    src_dout     = 8'($urandom);
    @(negedge clk);
    check("read_q", TRS_Q, model_q);
    check("read_oe", TRS_Q_OE, 1);
    check("read_wait", TRS_WAIT, 0);
    repeat (hold) begin
      tick();
      src_dout_rdy = ($urandom_range(0, 2) == 0);
      src_dout     = 8'($urandom);
    end
    tick();
    src_dout_rdy = 1'b0;
    if (rst_in_hold) apply_reset_checks("rst_hold");
    else end_in();
  endtask

  // TRS_IN dropped a cycles after the rise, optionally together with a ready pulse.
  task automatic do_abort(input int a, input bit with_rdy, input logic [7:0] data);
    push_ev(1'b0, model_q, a - 1);
    TRS_A  = SLOW_PORT;
    TRS_IN = 1'b1;
    repeat (a) tick();
    TRS_IN = 1'b0;
    if (with_rdy) begin
      src_dout     = data;
      src_dout_rdy = 1'b1;
    end
    tick();
    src_dout_rdy = 1'b0;
    @(negedge clk);
    check("abort_wait", TRS_WAIT, 0);
    check("abort_oe", TRS_Q_OE, 0);
    check("abort_q", TRS_Q, model_q);
    check("abort_busy", busy, 0);
  endtask

  task automatic do_reset_wait(input int r);
    model_flag = 1'b0;
    push_ev(1'b0, 8'h00, r - 1);
    TRS_A  = SLOW_PORT;
    TRS_IN = 1'b1;
    repeat (r) tick();
    apply_reset_checks("rst_wait");
  endtask

  // Wrong port, stray ready, then the right address while TRS_IN is already high.
  task automatic do_wrong_port();
    TRS_A  = 8'hED;
    TRS_IN = 1'b1;
    repeat (3) begin
      tick();
      @(negedge clk);
      check("wp_idle", {TRS_WAIT, TRS_Q_OE, busy}, 0);
    end
    src_dout     = 8'h33;
    src_dout_rdy = 1'b1;
    tick();
    src_dout_rdy = 1'b0;
    TRS_A        = SLOW_PORT;
    repeat (4) begin
      tick();
      @(negedge clk);
      check("level_no_start", {TRS_WAIT, TRS_Q_OE, busy}, 0);
    end
    check("wp_q_kept", TRS_Q, model_q);
    TRS_IN = 1'b0;
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    TRS_A        = 8'h00;
    TRS_IN       = 1'b0;
    src_dout     = 8'h00;
    src_dout_rdy = 1'b0;
    model_q      = 8'h00;
    model_flag   = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("reset_wait", TRS_WAIT, 0);
    check("reset_q", TRS_Q, 8'h00);
    check("reset_oe", TRS_Q_OE, 0);
    check("reset_busy", busy, 0);
    check("reset_tflag", timeout_flag, 0);
    reset = 1'b0;
    tick();

    do_read(6, 8'h5A, 3, 1'b0);
    do_wrong_port();
    do_abort(5, 1'b1, 8'h77);
`ifdef IN_WAIT_TIMEOUT_EN
    do_read(TIMEOUT + 1, 8'h12, 2, 1'b0);
    do_read(TIMEOUT + 6, 8'hA5, 2, 1'b0);
    do_read(4, 8'h3C, 2, 1'b0);
`endif
    do_reset_wait(7);
    do_read(5, 8'hC3, 2, 1'b1);
    do_read(3, 8'h81, 1, 1'b0);
    do_read(2, 8'h18, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    do_read(int'($urandom_range(2, 20)), 8'($urandom), int'($urandom_range(0, 4)), 1'b0);
        2:       do_abort(int'($urandom_range(2, 20)), 1'($urandom_range(0, 1)), 8'($urandom));
        default: do_wrong_port();
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("drain_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
